// File: rtl/led_ctrl_pkg.sv
// Shared constants and helpers for the LED controller: channel modes,
// phase/PWM widths, the breathe duty triangle and the per-channel mode mux.
package led_ctrl_pkg;

  localparam int PHASE_BITS = 8;
  localparam int PWM_BITS   = 7;

  typedef enum logic [1:0] {
    LED_MODE_OFF     = 2'd0,
    LED_MODE_ON      = 2'd1,
    LED_MODE_BLINK   = 2'd2,
    LED_MODE_BREATHE = 2'd3
  } led_mode_e;

  // Triangle over one phase period: ramps up in the first half, down in the second.
  function automatic logic [PWM_BITS-1:0] breathe_duty(input logic [PHASE_BITS-1:0] ph);
    return ph[PHASE_BITS-1] ? ~ph[PWM_BITS-1:0] : ph[PWM_BITS-1:0];
  endfunction

  function automatic logic chan_sel(input logic [1:0] m, input logic blink,
                                    input logic breathe);
    logic o;
    o = 1'b0;
    case (led_mode_e'(m))
      LED_MODE_OFF:     o = 1'b0;
      LED_MODE_ON:      o = 1'b1;
      LED_MODE_BLINK:   o = blink;
      LED_MODE_BREATHE: o = breathe;
      default:          o = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus tick-based debouncer for the push-button.
// Outputs the accepted (stable) level and a one-cycle pulse on its rising edge.
module button_debounce #(
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic button,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], button};
      level_d <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (tick) begin
        // The tick that would reach DEBOUNCE_TICKS flips the level instead of counting.
        if (cnt == LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller: shared prescaler/phase, per-channel mode mux,
// debounced button toggling a global inversion. Breathe PWM via LED_CTRL_BREATHE_EN.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NR_LEDS        = 4,
  parameter int PRESCALE_BITS  = 16,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2*NR_LEDS-1:0]   mode,
  input  logic                   button,
  output logic                   button_pressed,
  output logic [NR_LEDS-1:0]     leds
);

  logic [PRESCALE_BITS-1:0] presc;
  logic                     tick;
  logic [PHASE_BITS-1:0]    phase;
  logic                     blink_out;
  logic                     breathe_out;
  logic                     invert;
  logic                     btn_level;
  logic                     btn_rise;
  logic                     press;
  logic [NR_LEDS-1:0]       chan_out;

  assign tick = &presc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      phase <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (tick) phase <= phase + 1'b1;
    end
  end

  assign blink_out = phase[PHASE_BITS-1];

`ifdef LED_CTRL_BREATHE_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign duty        = breathe_duty(phase);
  assign breathe_out = pwm_cnt < duty;
`else
  // Without the PWM, breathe degrades to blink.
  assign breathe_out = blink_out;
`endif

  for (genvar i = 0; i < NR_LEDS; i++) begin : g_chan
    assign chan_out[i] = chan_sel(mode[2*i +: 2], blink_out, breathe_out);
  end

  button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .button  (button),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  assign press = btn_rise & btn_level;

  // invert flips on the pulse edge; leds pick up the new value one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      button_pressed <= 1'b0;
      invert         <= 1'b0;
      leds           <= '0;
    end else begin
      button_pressed <= press;
      invert         <= invert ^ press;
      leds           <= chan_out ^ {NR_LEDS{invert}};
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: table vectors for static modes, cycle-indexed reference
// model with a scoreboard queue for blink/breathe, hand sequences for button and reset.
module tb_led_ctrl;

  localparam int NL   = 4;
  localparam int PB   = 4;
  localparam int DT   = 3;
  localparam int TICK = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] mode = 8'h00;
  logic       button = 1'b0;
  logic       button_pressed;
  logic [3:0] leds;

  led_ctrl #(.NR_LEDS(NL), .PRESCALE_BITS(PB), .DEBOUNCE_TICKS(DT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mode           (mode),
    .button         (button),
    .button_pressed (button_pressed),
    .leds           (leds)
  );

  always #5 clk = ~clk;

  // Number of clock edges since reset release = index of the current DUT state.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int npulse = 0;
  int last_pulse = -1;
  always @(negedge clk) begin
    if (button_pressed === 1'b1) begin
      npulse     <= npulse + 1;
      last_pulse <= cyc;
    end
  end

  int         total = 0;
  int         bad = 0;
  logic       inv = 1'b0;
  logic [3:0] q[$];
  int         on_cnt[300];

  typedef struct {
    logic [7:0] mode;
    logic [3:0] exp;
  } vec_t;
  vec_t vt[8];

  function automatic logic [3:0] model(int c, logic [7:0] m, logic iv);
    logic [7:0] ph;
    logic [3:0] r;
`ifdef LED_CTRL_BREATHE_EN
    logic [6:0] pw;
    logic [6:0] duty;
`endif
    ph = 8'((c / TICK) % 256);
`ifdef LED_CTRL_BREATHE_EN
    pw   = 7'(c % 128);
    duty = ph[7] ? ~ph[6:0] : ph[6:0];
`endif
    r = 4'h0;
    for (int i = 0; i < NL; i++) begin
      case (m[2*i +: 2])
        2'd0: r[i] = 1'b0;
        2'd1: r[i] = 1'b1;
        2'd2: r[i] = ph[7];
        default: begin
`ifdef LED_CTRL_BREATHE_EN
          r[i] = (pw < duty);
`else
          r[i] = ph[7];
`endif
        end
      endcase
    end
    return r ^ {4{iv}};
  endfunction

  task automatic check(string nm, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Runs n cycles against the model; one scoreboard entry per cycle, one verdict per run.
  task automatic run(string nm, int n);
    int errs = 0;
    int fc = -1;
    int c0;
    logic [3:0] fg, fe, g, e;
    fg = 4'h0;
    fe = 4'h0;
    repeat (n) begin
      c0 = cyc;
      q.push_back(model(c0, mode, inv));
      @(posedge clk);
      @(negedge clk);
      g = leds;
      e = q.pop_front();
      if (c0 / TICK < 300) on_cnt[c0 / TICK] += int'(g[0]);
      if (g !== e) begin
        if (errs == 0) begin
          fc = c0;
          fg = g;
          fe = e;
        end
        errs++;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d cycle(s) wrong, first at state %0d leds=%h expected %h",
               nm, errs, fc, fg, fe);
    end
  endtask

  task automatic apply_table(string tag);
    logic [3:0] e;
    for (int k = 0; k < 8; k++) begin
      mode = vt[k].mode;
      q.push_back(vt[k].exp ^ {4{inv}});
      @(posedge clk);
      @(negedge clk);
      e = q.pop_front();
      check($sformatf("%s_mode%02h", tag, vt[k].mode), int'(leds), int'(e));
    end
  endtask

  task automatic press(string nm, int ticks, int expect_n);
    int p0;
    int t0;
    int j;
    p0 = npulse;
    t0 = cyc;
    button = 1'b1;
    repeat (ticks * TICK) @(negedge clk);
    button = 1'b0;
    repeat (8 * TICK) @(negedge clk);
    check({nm, "_pulses"}, npulse - p0, expect_n);
    if (expect_n == 1) begin
      // s2 valid from state t0+2; flip on the 3rd tick state j+32, pulse register one later.
      j = t0 + 2;
      while (j % TICK != TICK - 1) j++;
      check({nm, "_latency"}, last_pulse - t0, j + 34 - t0);
    end
  endtask

  initial begin
    vt[0] = '{8'h00, 4'h0};
    vt[1] = '{8'h55, 4'hF};
    vt[2] = '{8'h05, 4'h3};
    vt[3] = '{8'h50, 4'hC};
    vt[4] = '{8'h11, 4'h5};
    vt[5] = '{8'h44, 4'hA};
    vt[6] = '{8'h14, 4'h6};
    vt[7] = '{8'h41, 4'h9};

    repeat (3) @(negedge clk);
    check("rst_leds", int'(leds), 0);
    check("rst_pressed", int'(button_pressed), 0);
    check("rst_phase", int'(dut.phase), 0);
    reset_n = 1'b1;

    // 1: idle, everything off
    mode = 8'h00;
    run("idle_off", 10000);
    check("idle_no_pulse", npulse, 0);

    // 2: static table, then blink across two half periods
    apply_table("static");
    mode = 8'hAA;
    run("blink", 4300);

    // 3: glitch rejected, real press inverts
    mode = 8'h00;
    press("short", 2, 0);
    check("short_invert", int'(dut.invert), 0);
    press("long", 5, 1);
    inv = ~inv;
    check("long_invert", int'(dut.invert), 1);
    apply_table("inverted");

    // 5: async reset mid-blink with invert set
    mode = 8'hAA;
    run("blink_inv", 200);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_leds", int'(leds), 0);
    check("arst_invert", int'(dut.invert), 0);
    check("arst_phase", int'(dut.phase), 0);
    repeat (2) @(negedge clk);
    check("arst_hold_leds", int'(leds), 0);
    reset_n = 1'b1;
    inv = 1'b0;
    run("blink_after_rst", 300);
    check("phase_resume", int'(dut.phase), 300 / TICK);

    // 4: breathe duty at chosen phases (channel 0 on-cycles per 16-cycle phase window)
    for (int k = 0; k < 300; k++) on_cnt[k] = 0;
    mode = 8'hFF;
    run("breathe", 4200 - cyc);
`ifdef LED_CTRL_BREATHE_EN
    check("duty_ph0",   on_cnt[256], 0);
    check("duty_ph64",  on_cnt[64],  16);
    check("duty_ph127", on_cnt[127], 15);
    check("duty_ph200", on_cnt[200], 16);
`else
    check("duty_ph0",   on_cnt[256], 0);
    check("duty_ph64",  on_cnt[64],  0);
    check("duty_ph127", on_cnt[127], 0);
    check("duty_ph200", on_cnt[200], 16);
`endif

    // 6: mixed channels, invert and restore
    mode = 8'hE4;
    run("mixed", 600);
    press("mix1", 5, 1);
    inv = ~inv;
    run("mixed_inv", 600);
    press("mix2", 5, 1);
    inv = ~inv;
    run("mixed_restored", 600);
    check("final_invert", int'(dut.invert), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
